// File: rtl/seg7_frame_capture.sv
// Captures the 2-digit hex value shown on a multiplexed 7-segment bus.
// Each digit pattern must be stable for STABLE_CYCLES samples before it is accepted.
module seg7_frame_capture #(
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_in,
  input  logic       digit_in,
  input  logic       sync_in,
  output logic [7:0] value,
  output logic       value_valid,
  output logic       decode_err,
  output logic [1:0] blank,
  output logic       timeout,
  output logic       busy,
  output logic [7:0] frame_cnt
);

  localparam int SW = $clog2(STABLE_CYCLES);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES - 1);
  localparam logic [SW-1:0] STAB_PRE = SW'(STABLE_CYCLES - 2);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, EMIT} state_t;

  state_t        state_reg, state_next;
  logic          sync_q_reg;
  logic [7:0]    prev_reg;
  logic [SW-1:0] stab_cnt_reg, stab_cnt_next;
  logic [TW-1:0] to_cnt_reg, to_cnt_next;
  logic          got_lo_reg, got_lo_next, got_hi_reg, got_hi_next;
  logic [3:0]    lo_reg, lo_next, hi_reg, hi_next;
  logic [7:0]    value_reg, value_next;
  logic          value_valid_reg, value_valid_next;
  logic          decode_err_reg, decode_err_next;
  logic [1:0]    blank_reg, blank_next;
  logic          timeout_reg, timeout_next;
  logic          busy_reg;
  logic [7:0]    frame_cnt_reg, frame_cnt_next;

  logic       sync_edge, changed, start;
  logic [5:0] dec;

  // Result is {err, blank, nibble}; blank and unknown patterns both decode to 0.
  function automatic logic [5:0] decode_seg(input logic [6:0] s);
    case (s)
      7'h3F: return 6'h00;  7'h06: return 6'h01;  7'h5B: return 6'h02;  7'h4F: return 6'h03;
      7'h66: return 6'h04;  7'h6D: return 6'h05;  7'h7D: return 6'h06;  7'h07: return 6'h07;
      7'h7F: return 6'h08;  7'h6F: return 6'h09;  7'h77: return 6'h0A;  7'h7C: return 6'h0B;
      7'h39: return 6'h0C;  7'h5E: return 6'h0D;  7'h79: return 6'h0E;  7'h71: return 6'h0F;
      7'h00: return 6'b01_0000;
      default: return 6'b10_0000;
    endcase
  endfunction

  assign sync_edge = sync_in & ~sync_q_reg;
  assign changed   = ({digit_in, seg_in} != prev_reg);
  assign dec       = decode_seg(seg_in);

  always_comb begin
    state_next       = state_reg;
    stab_cnt_next    = stab_cnt_reg;
    to_cnt_next      = to_cnt_reg;
    got_lo_next      = got_lo_reg;
    got_hi_next      = got_hi_reg;
    lo_next          = lo_reg;
    hi_next          = hi_reg;
    value_next       = value_reg;
    value_valid_next = 1'b0;
    decode_err_next  = decode_err_reg;
    blank_next       = blank_reg;
    timeout_next     = 1'b0;
    frame_cnt_next   = frame_cnt_reg;
    start            = 1'b0;
    case (state_reg)
      IDLE: begin
        if (sync_edge) begin
          state_next = CAPTURE;
          start      = 1'b1;
        end
      end
      CAPTURE: begin
        to_cnt_next = to_cnt_reg + 1'b1;
        if (changed) begin
          stab_cnt_next = '0;
        end else if (stab_cnt_reg != STAB_MAX) begin
          stab_cnt_next = stab_cnt_reg + 1'b1;
        end
        // Accept only on the transition into the saturated count, not while holding there.
        if (!changed && stab_cnt_reg == STAB_PRE) begin
          if (digit_in) begin
            hi_next     = dec[3:0];
            got_hi_next = 1'b1;
          end else begin
            lo_next     = dec[3:0];
            got_lo_next = 1'b1;
          end
          blank_next[digit_in] = dec[4];
          if (dec[5]) decode_err_next = 1'b1;
        end
        if (sync_edge) begin
          start = 1'b1;
        end else if (got_lo_next && got_hi_next) begin
          state_next = EMIT;
        end else if (to_cnt_reg == TO_MAX) begin
          timeout_next = 1'b1;
          state_next   = IDLE;
        end
      end
      EMIT: begin
        value_next       = {hi_reg, lo_reg};
        value_valid_next = 1'b1;
        frame_cnt_next   = frame_cnt_reg + 1'b1;
        if (sync_edge) begin
          state_next = CAPTURE;
          start      = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (start) begin
      got_lo_next     = 1'b0;
      got_hi_next     = 1'b0;
      stab_cnt_next   = '0;
      to_cnt_next     = '0;
      decode_err_next = 1'b0;
      blank_next      = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      sync_q_reg      <= 1'b0;
      prev_reg        <= '0;
      stab_cnt_reg    <= '0;
      to_cnt_reg      <= '0;
      got_lo_reg      <= 1'b0;
      got_hi_reg      <= 1'b0;
      lo_reg          <= '0;
      hi_reg          <= '0;
      value_reg       <= '0;
      value_valid_reg <= 1'b0;
      decode_err_reg  <= 1'b0;
      blank_reg       <= '0;
      timeout_reg     <= 1'b0;
      busy_reg        <= 1'b0;
      frame_cnt_reg   <= '0;
    end else begin
      state_reg       <= state_next;
      sync_q_reg      <= sync_in;
      prev_reg        <= {digit_in, seg_in};
      stab_cnt_reg    <= stab_cnt_next;
      to_cnt_reg      <= to_cnt_next;
      got_lo_reg      <= got_lo_next;
      got_hi_reg      <= got_hi_next;
      lo_reg          <= lo_next;
      hi_reg          <= hi_next;
      value_reg       <= value_next;
      value_valid_reg <= value_valid_next;
      decode_err_reg  <= decode_err_next;
      blank_reg       <= blank_next;
      timeout_reg     <= timeout_next;
      busy_reg        <= (state_next != IDLE);
      frame_cnt_reg   <= frame_cnt_next;
    end
  end

  assign value       = value_reg;
  assign value_valid = value_valid_reg;
  assign decode_err  = decode_err_reg;
  assign blank       = blank_reg;
  assign timeout     = timeout_reg;
  assign busy        = busy_reg;
  assign frame_cnt   = frame_cnt_reg;

endmodule
